// File: rtl/dcache_pkg.sv
// Shared constants, state encoding and address-split helpers for the data cache.
// Optional refill-to-load forwarding is built when DCACHE_FWD_EN is defined.
package dcache_pkg;

  localparam int DC_ADDR_W  = 10;
  localparam int DC_DATA_W  = 32;
  localparam int DC_INDEX_W = 5;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = DC_ADDR_W - OFFSET_W - DC_INDEX_W;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t REFILL = 2'd1;
  localparam state_t WRITE  = 2'd2;

  function automatic logic [DC_INDEX_W-1:0] addr_index(
    input logic [DC_ADDR_W-1:0] a
  );
    return a[OFFSET_W +: DC_INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [DC_ADDR_W-1:0] a
  );
    return a[DC_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(
    input logic [DC_ADDR_W-1:0] a
  );
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational lookup, one write port (line or word).
// Valid bits clear synchronously on RST; tag and data arrays are not reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = DC_INDEX_W,
  parameter int DATA_W  = DC_DATA_W
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [INDEX_W-1:0]           rd_idx,
  input  logic [OFFSET_W-1:0]          rd_off,
  input  logic [TAG_W-1:0]             rd_tag,
  output logic                         hit,
  output logic [DATA_W-1:0]            rdata,
  input  logic                         line_we,
  input  logic                         word_we,
  input  logic [INDEX_W-1:0]           wr_idx,
  input  logic [OFFSET_W-1:0]          wr_off,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [LINE_WORDS*DATA_W-1:0] line_wd,
  input  logic [DATA_W-1:0]            word_wd
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES][LINE_WORDS];

  assign hit   = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rdata = valid[rd_idx] ? data[rd_idx][rd_off] : '0;

  always_ff @(posedge clk) begin
    if (RST)
      valid <= '0;
    else if (line_we)
      valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[wr_idx] <= wr_tag;
      for (int k = 0; k < LINE_WORDS; k++)
        data[wr_idx][k] <= line_wd[k*DATA_W +: DATA_W];
    end else if (word_we) begin
      data[wr_idx][wr_off] <= word_wd;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// DCACHE_FWD_EN forwards the refilled word to the load in the mem_ready cycle.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = DC_ADDR_W,
  parameter int DATA_W  = DC_DATA_W,
  parameter int INDEX_W = DC_INDEX_W
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         cpu_rd_en,
  input  logic                         cpu_wr_en,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wd,
  output logic [DATA_W-1:0]            cpu_rd,
  output logic                         stall,
  output logic                         mem_rd_en,
  output logic                         mem_miss,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wd,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rd,
  input  logic                         mem_ready
);

  state_t state, nxt;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] off;
  logic                hit;
  logic [DATA_W-1:0]   arr_rd;
  logic                line_we, word_we;

  assign idx = addr_index(cpu_addr);
  assign tag = addr_tag(cpu_addr);
  assign off = addr_offset(cpu_addr);

  dcache_array #(
    .INDEX_W (INDEX_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk     (clk),
    .RST     (RST),
    .rd_idx  (idx),
    .rd_off  (off),
    .rd_tag  (tag),
    .hit     (hit),
    .rdata   (arr_rd),
    .line_we (line_we & ~RST),
    .word_we (word_we & ~RST),
    .wr_idx  (idx),
    .wr_off  (off),
    .wr_tag  (tag),
    .line_wd (mem_rd),
    .word_wd (cpu_wd)
  );

  always_comb begin
    nxt     = state;
    stall   = 1'b0;
    cpu_rd  = arr_rd;
    line_we = 1'b0;
    word_we = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr_en) begin
          stall   = 1'b1;
          word_we = hit;
          nxt     = WRITE;
        end else if (cpu_rd_en && !hit) begin
          stall = 1'b1;
          nxt   = REFILL;
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (mem_ready) begin
          line_we = 1'b1;
          nxt     = IDLE;
`ifdef DCACHE_FWD_EN
          stall   = 1'b0;
          cpu_rd  = mem_rd[off*DATA_W +: DATA_W];
`endif
        end
      end
      WRITE: begin
        stall = !mem_ready;
        if (mem_ready)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Memory side is Moore: enables come from the registered state only.
  always_comb begin
    mem_rd_en = (state == REFILL);
    mem_miss  = (state == REFILL);
    mem_wr_en = (state == WRITE);
    mem_addr  = '0;
    mem_wd    = '0;
    if (state == REFILL)
      mem_addr = {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    else if (state == WRITE) begin
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (RST)
      state <= IDLE;
    else
      state <= nxt;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores against a
// latency-programmable memory model; a monitor checks retirements and transfers.
module tb_dcache_ctrl;

  logic          clk = 1'b0;
  logic          RST;
  logic          cpu_rd_en, cpu_wr_en;
  logic [9:0]    cpu_addr;
  logic [31:0]   cpu_wd;
  logic [31:0]   cpu_rd;
  logic          stall;
  logic          mem_rd_en, mem_miss, mem_wr_en;
  logic [9:0]    mem_addr;
  logic [31:0]   mem_wd;
  logic [127:0]  mem_rd;
  logic          mem_ready;

  logic [31:0] mem [1024];
  int lat;
  int n_chk = 0;
  int n_fail = 0;

`ifdef DCACHE_FWD_EN
  localparam int MISS_EXTRA = 1;
`else
  localparam int MISS_EXTRA = 2;
`endif

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          stalls;
  } rq_t;

  typedef struct {
    bit          is_wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } mq_t;

  rq_t rq[$];
  mq_t mq[$];

  dcache_ctrl dut (
    .clk       (clk),
    .RST       (RST),
    .cpu_rd_en (cpu_rd_en),
    .cpu_wr_en (cpu_wr_en),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .stall     (stall),
    .mem_rd_en (mem_rd_en),
    .mem_miss  (mem_miss),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  assign mem_rd = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                   mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ready pulses after lat extra cycles of an active request.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!RST && (mem_rd_en || mem_wr_en) && !mem_ready) begin
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          cnt = 0;
          if (mem_wr_en) mem[mem_addr] = mem_wd;
        end else begin
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations on memory completion and on core retirement.
  initial begin
    int scnt;
    rq_t r;
    mq_t m;
    scnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (RST) begin
        scnt = 0;
      end else begin
        if (mem_ready && (mem_rd_en || mem_wr_en)) begin
          if (mq.size() == 0) begin
            chk("mem_unexpected", {31'd0, mem_wr_en}, 32'hFFFF_FFFF);
          end else begin
            m = mq.pop_front();
            chk("mem_is_wr", {31'd0, mem_wr_en}, {31'd0, m.is_wr});
            chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, !m.is_wr});
            chk("mem_miss", {31'd0, mem_miss}, {31'd0, !m.is_wr});
            chk("mem_addr", {22'd0, mem_addr}, {22'd0, m.addr});
            if (m.is_wr) chk("mem_wd", mem_wd, m.data);
          end
        end
        if (cpu_rd_en || cpu_wr_en) begin
          if (stall) begin
            scnt++;
          end else begin
            if (rq.size() == 0) begin
              chk("retire_unexpected", 32'd1, 32'd0);
            end else begin
              r = rq.pop_front();
              chk("stall_cycles", scnt, r.stalls);
              if (r.is_load) chk("cpu_rd", cpu_rd, r.data);
            end
            scnt = 0;
          end
        end
      end
    end
  end

  task automatic req(input bit rd, input bit wr, input logic [9:0] a,
                     input logic [31:0] wd);
    bit done;
    done = 0;
    cpu_rd_en = rd;
    cpu_wr_en = wr;
    cpu_addr  = a;
    cpu_wd    = wd;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #2;
      if (!stall) done = 1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: stall still %b at addr %h", stall, a);
    end
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d,
                      input bit miss);
    rq.push_back('{1'b1, d, miss ? lat + MISS_EXTRA : 0});
    if (miss) mq.push_back('{1'b0, {a[9:2], 2'b00}, 32'd0});
    req(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic store(input bit also_rd, input logic [9:0] a,
                       input logic [31:0] d);
    rq.push_back('{1'b0, 32'd0, lat + 1});
    mq.push_back('{1'b1, a, d});
    req(also_rd, 1'b1, a, d);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = f(i[9:0]);
    lat = 2;
    RST = 1'b1;
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    cpu_addr = 10'h004;
    cpu_wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    chk("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_mem_miss", {31'd0, mem_miss}, 32'd0);
    chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_cpu_rd", cpu_rd, 32'd0);
    @(posedge clk);
    #1;

    load(10'h004, f(10'h004), 1);
    load(10'h005, f(10'h005), 0);
    store(1'b0, 10'h006, 32'hDEAD_BEEF);
    load(10'h006, 32'hDEAD_BEEF, 0);
    store(1'b0, 10'h104, 32'h1234_5678);
    load(10'h104, 32'h1234_5678, 1);
    load(10'h004, f(10'h004), 1);
    lat = 0;
    load(10'h00F, f(10'h00F), 1);
    load(10'h00C, f(10'h00C), 0);
    lat = 3;
    store(1'b0, 10'h00D, 32'hA5A5_0001);
    load(10'h00D, 32'hA5A5_0001, 0);

    // Reset in the second refill cycle abandons the fill of line 0x008.
    lat = 5;
    cpu_rd_en = 1'b1;
    cpu_addr = 10'h008;
    @(posedge clk);
    #1;
    chk("refill_rd_en", {31'd0, mem_rd_en}, 32'd1);
    chk("refill_addr", {22'd0, mem_addr}, 32'h008);
    chk("refill_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    RST = 1'b1;
    cpu_rd_en = 1'b0;
    @(posedge clk);
    #1;
    RST = 1'b0;
    chk("abort_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("abort_miss", {31'd0, mem_miss}, 32'd0);
    chk("abort_addr", {22'd0, mem_addr}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    lat = 2;
    load(10'h004, f(10'h004), 1);
    load(10'h008, f(10'h008), 1);
    store(1'b1, 10'h009, 32'h0BAD_F00D);
    load(10'h009, 32'h0BAD_F00D, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("rq_drained", rq.size(), 32'd0);
    chk("mq_drained", mq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
